// File: rtl/rom_server.sv
// ROM byte server: maps byte requests onto a 32-bit backing memory through a
// single-word buffer, refetching on miss or after invalidation.
`timescale 1ns/1ps

module rom_server #(
    parameter logic [31:0] BASE = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] romaddr,
    input  logic        romreq,
    output logic        romack,
    output logic [7:0]  romdata,
    input  logic        inval,
    output logic [29:0] maddr,
    output logic        mreq,
    input  logic        mack,
    input  logic [31:0] mdata
);

    localparam logic [29:0] BaseWord = BASE[31:2];

    typedef enum logic [1:0] {StIdle, StFetch, StAck, StHold} state_t;

    state_t      r_state;
    logic        r_valid;
    logic [19:0] r_tag;
    logic [31:0] r_data;
    logic        r_inval_pend;
    logic        r_romack;
    logic [7:0]  r_romdata;
    logic [29:0] r_maddr;
    logic        r_mreq;

    logic        w_hit;
    logic [7:0]  w_buf_byte;
    logic [7:0]  w_fill_byte;
    logic [29:0] w_fetch_addr;

    always_comb begin
        w_hit        = r_valid && (r_tag == romaddr[21:2]);
        w_buf_byte   = r_data[{romaddr[1:0], 3'b000} +: 8];
        w_fill_byte  = mdata[{romaddr[1:0], 3'b000} +: 8];
        w_fetch_addr = BaseWord + {10'b0, romaddr[21:2]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_valid      <= 1'b0;
            r_tag        <= '0;
            r_data       <= '0;
            r_inval_pend <= 1'b0;
            r_romack     <= 1'b0;
            r_romdata    <= 8'h00;
            r_maddr      <= '0;
            r_mreq       <= 1'b0;
        end else begin
            r_romack <= 1'b0;
            // During a fetch the invalidate is deferred so the fill lands invalid.
            if (inval && (r_state != StFetch)) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                StIdle: begin
                    if (romreq) begin
                        if (w_hit && !inval) begin
                            r_state   <= StAck;
                            r_romack  <= 1'b1;
                            r_romdata <= w_buf_byte;
                        end else begin
                            r_state      <= StFetch;
                            r_maddr      <= w_fetch_addr;
                            r_mreq       <= 1'b1;
                            r_inval_pend <= 1'b0;
                        end
                    end
                end
                StFetch: begin
                    if (inval) begin
                        r_inval_pend <= 1'b1;
                    end
                    if (mack) begin
                        r_mreq    <= 1'b0;
                        r_data    <= mdata;
                        r_tag     <= romaddr[21:2];
                        r_valid   <= !(inval || r_inval_pend);
                        r_romack  <= 1'b1;
                        r_romdata <= w_fill_byte;
                        r_state   <= StAck;
                    end
                end
                StAck:   r_state <= StHold;
                StHold:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign romack  = r_romack;
    assign romdata = r_romdata;
    assign maddr   = r_maddr;
    assign mreq    = r_mreq;

endmodule

// File: tb/tb_rom_server.sv
// Randomized scoreboard bench for rom_server: static memory image, abstract
// buffer model (valid/tag), monitor checks data, fetch count, address and latency.
`timescale 1ns/1ps

module tb_rom_server;

    localparam logic [31:0] BASE   = 32'h00100000;
    localparam logic [29:0] BASE_W = 30'(BASE >> 2);

    logic        clk = 1'b0;
    logic        reset;
    logic [21:0] romaddr;
    logic        romreq;
    logic        romack;
    logic [7:0]  romdata;
    logic        inval_d, inval_m, inval;
    logic [29:0] maddr;
    logic        mreq;
    logic        mack_m, mack_d, mack;
    logic [31:0] mdata;

    assign inval = inval_d | inval_m;
    assign mack  = mack_m | mack_d;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rom_server #(.BASE(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .romaddr (romaddr),
        .romreq  (romreq),
        .romack  (romack),
        .romdata (romdata),
        .inval   (inval),
        .maddr   (maddr),
        .mreq    (mreq),
        .mack    (mack),
        .mdata   (mdata)
    );

    typedef struct {
        logic [7:0]  data;
        bit          hit;
        logic [29:0] maddr;
        int          ack_cyc;
    } exp_t;

    exp_t sb[$];
    int n_pass = 0;
    int n_total = 0;

    // Memory-side bookkeeping (owned by the memory process)
    int          n_mack = 0;
    int          mack_edge = 0;
    logic [29:0] fetched_maddr = '0;
    // Driver-owned controls read by the memory process
    int          force_delay = -1;
    bit          with_mack_inval = 1'b0;
    bit          abort_fetch = 1'b0;

    // Abstract buffer model
    bit          m_valid = 1'b0;
    logic [19:0] m_tag = '0;

    function automatic logic [31:0] mem_word(logic [29:0] a);
        if (a == BASE_W) return 32'hDDCCBBAA;
        return ({2'b00, a} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Backing memory: random latency, checks request stability while waiting
    initial begin : memory
        logic [29:0] a;
        int d;
        bit ab;
        mack_m  = 1'b0;
        inval_m = 1'b0;
        mdata   = '0;
        forever begin
            @(negedge clk);
            mack_m  = 1'b0;
            inval_m = 1'b0;
            if (mreq && !reset) begin
                a  = maddr;
                d  = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
                ab = 1'b0;
                for (int i = 0; i < d; i++) begin
                    @(negedge clk);
                    if (abort_fetch) begin
                        ab = 1'b1;
                        break;
                    end
                    check("mreq_stable", {31'b0, mreq}, 32'd1);
                    check("maddr_stable", {2'b0, maddr}, {2'b0, a});
                end
                if (!ab) begin
                    mack_m        = 1'b1;
                    mdata         = mem_word(a);
                    inval_m       = with_mack_inval;
                    fetched_maddr = a;
                    mack_edge     = cyc + 1;
                    n_mack++;
                end
            end
        end
    end

    // Monitor: pops one expectation per romack
    initial begin : monitor
        exp_t e;
        logic [7:0] last_data;
        int acked_macks;
        last_data   = 8'h00;
        acked_macks = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_data = 8'h00;
            end else if (romack) begin
                if (sb.size() == 0) begin
                    check("unexpected_romack", {31'b0, romack}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("romdata", {24'b0, romdata}, {24'b0, e.data});
                    check("mack_count", n_mack - acked_macks, e.hit ? 0 : 1);
                    acked_macks = n_mack;
                    if (e.hit) begin
                        check("hit_latency", cyc, e.ack_cyc);
                    end else begin
                        check("miss_latency", cyc, mack_edge);
                        check("fetch_maddr", {2'b0, fetched_maddr}, {2'b0, e.maddr});
                    end
                    last_data = e.data;
                end
            end else begin
                check("romdata_hold", {24'b0, romdata}, {24'b0, last_data});
            end
        end
    end

    // mode: 0 none, 1 inval with the IDLE sample, 2 inval with mack, 3 inval early in FETCH
    task automatic do_req(logic [21:0] addr, int mode_in, bit hold);
        exp_t e;
        logic [31:0] ba;
        logic [31:0] w;
        int mode;
        bit pulsed;
        bit got;
        mode  = mode_in;
        e.hit = m_valid && (m_tag == addr[21:2]) && (mode != 1);
        if (e.hit && mode > 1) mode = 0;
        ba        = BASE + {10'b0, addr[21:2], 2'b00};
        e.maddr   = ba[31:2];
        w         = mem_word(e.maddr);
        e.data    = w[{addr[1:0], 3'b000} +: 8];
        e.ack_cyc = cyc + 1;
        sb.push_back(e);
        romaddr         = addr;
        romreq          = 1'b1;
        inval_d         = (mode == 1);
        with_mack_inval = (mode == 2);
        pulsed          = 1'b0;
        got             = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            inval_d = 1'b0;
            if (romack) begin
                got = 1'b1;
                break;
            end
            if (mode == 3 && mreq && !pulsed) begin
                inval_d = 1'b1;
                pulsed  = 1'b1;
            end
        end
        if (!got) begin
            check("ack_timeout", {31'b0, romack}, 32'd1);
            sb.delete();
        end
        if (!e.hit) begin
            m_tag   = addr[21:2];
            m_valid = !(mode == 2 || mode == 3);
        end
        with_mack_inval = 1'b0;
        if (!hold) romreq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        romreq = 1'b0;
    endtask

    task automatic gap(bit do_inval);
        int n;
        if (do_inval) begin
            inval_d = 1'b1;
            @(negedge clk);
            inval_d = 1'b0;
            m_valid = 1'b0;
        end
        n = int'($urandom_range(0, 2));
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin : driver
        logic [19:0] tags [4];
        logic [21:0] addr;
        int base_macks;
        bit got_mreq;
        tags[0] = 20'h00000;
        tags[1] = 20'h00041;
        tags[2] = 20'h00082;
        tags[3] = 20'hFFFFF;
        reset   = 1'b1;
        romreq  = 1'b0;
        romaddr = '0;
        inval_d = 1'b0;
        mack_d  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_romack", {31'b0, romack}, 32'd0);
        check("rst_romdata", {24'b0, romdata}, 32'd0);
        check("rst_mreq", {31'b0, mreq}, 32'd0);
        check("rst_maddr", {2'b0, maddr}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Miss then hit on the first image word
        do_req(22'h000000, 0, 1'b0);
        check("miss_byte0", {24'b0, romdata}, 32'h000000AA);
        check("first_maddr", {2'b0, fetched_maddr}, 32'h00040000);
        do_req(22'h000003, 0, 1'b0);
        check("hit_byte3", {24'b0, romdata}, 32'h000000DD);
        // Base offset
        do_req(22'h000104, 0, 1'b0);
        check("base_maddr", {2'b0, fetched_maddr}, 32'h00040041);
        // Slow memory, then a held request on the buffered word
        force_delay = 20;
        do_req(22'h000208, 0, 1'b0);
        force_delay = -1;
        do_req(22'h000209, 0, 1'b1);
        // Invalidate alongside mack forces a refetch
        do_req(22'h00030C, 2, 1'b0);
        base_macks = n_mack;
        do_req(22'h00030D, 0, 1'b0);
        check("refetch_after_inval", n_mack - base_macks, 1);

        // Reset in the middle of a slow fetch, followed by a stray mack
        addr        = {m_tag + 20'd1, 2'b01};
        force_delay = 30;
        romaddr     = addr;
        romreq      = 1'b1;
        got_mreq    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mreq) begin
                got_mreq = 1'b1;
                break;
            end
        end
        check("rstfetch_mreq_seen", {31'b0, got_mreq}, 32'd1);
        @(negedge clk);
        #2;
        abort_fetch = 1'b1;
        reset       = 1'b1;
        #1;
        check("rstfetch_mreq", {31'b0, mreq}, 32'd0);
        check("rstfetch_maddr", {2'b0, maddr}, 32'd0);
        check("rstfetch_romack", {31'b0, romack}, 32'd0);
        @(negedge clk);
        romreq = 1'b0;
        #2;
        reset = 1'b0;
        @(negedge clk);
        abort_fetch = 1'b0;
        force_delay = -1;
        m_valid     = 1'b0;
        mack_d      = 1'b1;
        @(negedge clk);
        mack_d = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stray_mack_mreq", {31'b0, mreq}, 32'd0);
            check("stray_mack_romack", {31'b0, romack}, 32'd0);
        end
        do_req(addr, 0, 1'b0);

        // Randomized traffic over a small tag pool so hits are frequent
        for (int t = 0; t < 300; t++) begin
            int mode;
            addr = {tags[$urandom_range(0, 3)], 2'($urandom_range(0, 3))};
            mode = int'($urandom_range(0, 6));
            if (mode > 3) mode = 0;
            do_req(addr, mode, $urandom_range(0, 3) == 0);
            gap($urandom_range(0, 9) == 0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
